rsrx_01a: RTL and testbench

UART receive-side deframer. It pairs with the team's `rstx` transmitter on the F25Clk domain. It oversamples an asynchronous serial line, detects 8N1 frames (start bit, 8 data bits LSB first, one stop bit) and presents each received byte on a parallel bus with a valid pulse, a full/read handshake and error flags. It sits between the board RX pin and the camera command decoder.

---
 rtl/rsrx_01a.sv | 179 +++++++++++++++++
 tb/tb_rsrx_01a.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsrx_01a.sv
// rtl/rsrx_01a.sv - UART 8N1 receive deframer with byte buffer, overrun and frame-error flags.
// Optional macro RSRX_MAJORITY_EN: each bit decision is a 3-sample majority vote.
module rsrx_01a #(
    parameter int unsigned P_CLK_PER_BIT = 217
) (
    input  logic       F25Clk,
    input  logic       reset_n,
    input  logic       rxSerialData,
    input  logic       rxRead,
    output logic [7:0] rxParallelData,
    output logic       rxValid,
    output logic       rxFull,
    output logic       rxFrameErr,
    output logic       rxOverrun,
    output logic       rxBusy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] HALF_LOAD = 16'(P_CLK_PER_BIT / 2);
`ifdef RSRX_MAJORITY_EN
    // The decision lands one cycle after expiry, so reload one less to keep the bit pitch.
    localparam logic [15:0] FULL_LOAD = 16'(P_CLK_PER_BIT - 2);
`else
    localparam logic [15:0] FULL_LOAD = 16'(P_CLK_PER_BIT - 1);
`endif

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        full_q, full_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;

    logic        fall;
    logic        tick;
    logic        sample;
    logic        good_stop;

`ifdef RSRX_MAJORITY_EN
    logic        pend_q, pend_d;
    logic        s_t1_q, s_t1_d;
    logic        s_t0_q, s_t0_d;
`endif

    always_comb begin
        fall = prev_q & ~sync2_q;
`ifdef RSRX_MAJORITY_EN
        pend_d = (state_q != S_IDLE) && (timer_q == 16'd0) && !pend_q;
        s_t1_d = (timer_q == 16'd1) ? sync2_q : s_t1_q;
        s_t0_d = ((timer_q == 16'd0) && !pend_q) ? sync2_q : s_t0_q;
        tick   = pend_q;
        sample = (s_t1_q & s_t0_q) | (s_t1_q & sync2_q) | (s_t0_q & sync2_q);
`else
        tick   = (state_q != S_IDLE) && (timer_q == 16'd0);
        sample = sync2_q;
`endif

        state_d   = state_q;
        timer_d   = (timer_q != 16'd0) ? timer_q - 16'd1 : timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        good_stop = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    timer_d = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sample) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d   = FULL_LOAD;
                        bit_cnt_d = 3'd0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {sample, shift_q[7:1]};
                    timer_d   = FULL_LOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d   = S_IDLE;
                    good_stop = sample;
                    ferr_d    = ~sample;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = good_stop;
        data_d  = good_stop ? shift_q : data_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        if (rxRead && full_q) begin
            full_d = 1'b0;
            ovr_d  = 1'b0;
        end
        // A read landing with a new byte consumes the old one: no overrun, buffer stays full.
        if (good_stop) begin
            full_d = 1'b1;
            ovr_d  = (full_q && !rxRead) ? 1'b1 : ovr_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge F25Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RSRX_MAJORITY_EN
            pend_q    <= 1'b0;
            s_t1_q    <= 1'b1;
            s_t0_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sync1_q   <= rxSerialData;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            data_q    <= data_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
`ifdef RSRX_MAJORITY_EN
            pend_q    <= pend_d;
            s_t1_q    <= s_t1_d;
            s_t0_q    <= s_t0_d;
`endif
        end
    end

    assign rxParallelData = data_q;
    assign rxValid        = valid_q;
    assign rxFull         = full_q;
    assign rxFrameErr     = ferr_q;
    assign rxOverrun      = ovr_q;
    assign rxBusy         = busy_q;

endmodule

// File: tb/tb_rsrx_01a.sv
// tb/tb_rsrx_01a.sv - randomized self-checking bench for rsrx_01a against a frame-level model.
module tb_rsrx_01a;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef RSRX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT = H + 9 * N + 3 + MAJ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, rx_ferr, rx_ovr, rx_busy;

    rsrx_01a #(.P_CLK_PER_BIT(N)) dut (
        .F25Clk        (clk),
        .reset_n       (rst_n),
        .rxSerialData  (rx),
        .rxRead        (rd),
        .rxParallelData(rx_data),
        .rxValid       (rx_valid),
        .rxFull        (rx_full),
        .rxFrameErr    (rx_ferr),
        .rxOverrun     (rx_ovr),
        .rxBusy        (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    int v_cnt = 0, f_cnt = 0, last_v = -1, last_f = -1;
    int both_cnt = 0, wide_cnt = 0;
    logic pv = 1'b0, pf = 1'b0, busy_seen = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin v_cnt++; last_v = cyc; end
        if (rx_ferr) begin f_cnt++; last_f = cyc; end
        if (rx_valid && rx_ferr) both_cnt++;
        if ((rx_valid && pv) || (rx_ferr && pf)) wide_cnt++;
        pv = rx_valid;
        pf = rx_ferr;
        if (rx_busy) busy_seen = 1'b1;
    end

    // Frame-level reference: buffered byte, full and overrun flags.
    logic [7:0] m_data = 8'h00;
    logic       m_full = 1'b0;
    logic       m_ovr  = 1'b0;

    task automatic model_good(input logic [7:0] b, input logic read_same);
        if (m_full && !read_same) m_ovr = 1'b1;
        m_full = 1'b1;
        m_data = b;
    endtask

    task automatic model_read();
        if (m_full) begin m_full = 1'b0; m_ovr = 1'b0; end
    endtask

    // Serialises one 8N1 frame starting at the current negedge; bit slot c lands on edge t0+c.
    task automatic send_frame(input logic [7:0] b, input logic stp, input int glitch, output int t0);
        logic [9:0] bits;
        bits = {stp, b, 1'b0};
        t0 = cyc + 1;
        for (int c = 0; c < 10 * N; c++) begin
            rx = bits[c / N] ^ (c == glitch);
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_read();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        model_read();
    endtask

    task automatic test_reset();
        total++;
        if ({rx_data, rx_valid, rx_full, rx_ferr, rx_ovr, rx_busy} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {rx_data, rx_valid, rx_full, rx_ferr, rx_ovr, rx_busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_frame(input logic [7:0] b);
        int t0, v0, f0;
        v0 = v_cnt; f0 = f_cnt;
        send_frame(b, 1'b1, -1, t0);
        model_good(b, 1'b0);
        total++;
        if (v_cnt !== v0 + 1 || f_cnt !== f0) begin
            bad++;
            $display("FAIL good_pulses valid=%0d ferr=%0d exp valid=%0d ferr=%0d", v_cnt - v0, f_cnt - f0, 1, 0);
        end
        total++;
        if (last_v !== t0 + LAT) begin
            bad++;
            $display("FAIL good_latency got=%0d exp=%0d", last_v - t0, LAT);
        end
        total++;
        if ({rx_data, rx_full, rx_ovr} !== {m_data, m_full, m_ovr}) begin
            bad++;
            $display("FAIL good_state got=%h/%b/%b exp=%h/%b/%b", rx_data, rx_full, rx_ovr, m_data, m_full, m_ovr);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_false_start();
        int v0, f0;
        v0 = v_cnt; f0 = f_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL false_start_busy seen=%b now=%b exp seen=1 now=0", busy_seen, rx_busy);
        end
        total++;
        if (v_cnt !== v0 || f_cnt !== f0) begin
            bad++;
            $display("FAIL false_start_pulses valid=%0d ferr=%0d exp=0", v_cnt - v0, f_cnt - f0);
        end
    endtask

    task automatic test_frame_err(input logic [7:0] b);
        int t0, v0, f0;
        v0 = v_cnt; f0 = f_cnt;
        send_frame(b, 1'b0, -1, t0);
        total++;
        if (f_cnt !== f0 + 1 || v_cnt !== v0 || last_f !== t0 + LAT) begin
            bad++;
            $display("FAIL frame_err ferr=%0d valid=%0d lat=%0d exp ferr=1 valid=0 lat=%0d", f_cnt - f0, v_cnt - v0, last_f - t0, LAT);
        end
        total++;
        if ({rx_data, rx_full, rx_ovr} !== {m_data, m_full, m_ovr}) begin
            bad++;
            $display("FAIL frame_err_state got=%h/%b/%b exp=%h/%b/%b", rx_data, rx_full, rx_ovr, m_data, m_full, m_ovr);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t0, t1, v0;
        v0 = v_cnt;
        send_frame(8'h11, 1'b1, -1, t0);
        model_good(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, -1, t1);
        model_good(8'h22, 1'b0);
        total++;
        if (v_cnt !== v0 + 2 || last_v !== t1 + LAT) begin
            bad++;
            $display("FAIL b2b_pulses got=%0d lat=%0d exp=2 lat=%0d", v_cnt - v0, last_v - t1, LAT);
        end
        total++;
        if ({rx_data, rx_full, rx_ovr} !== {m_data, m_full, m_ovr}) begin
            bad++;
            $display("FAIL b2b_overrun got=%h/%b/%b exp=%h/%b/%b", rx_data, rx_full, rx_ovr, m_data, m_full, m_ovr);
        end
        pulse_read();
        total++;
        if ({rx_full, rx_ovr} !== {m_full, m_ovr}) begin
            bad++;
            $display("FAIL b2b_read got=%b%b exp=%b%b", rx_full, rx_ovr, m_full, m_ovr);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_coincide();
        int t0;
        logic [7:0] b;
        b = 8'($urandom);
        send_frame(8'($urandom), 1'b1, -1, t0);
        model_good(rx_data, 1'b0);
        m_data = rx_data;
        send_frame(8'($urandom), 1'b1, -1, t0);
        model_good(rx_data, 1'b0);
        m_data = rx_data;
        fork
            send_frame(b, 1'b1, -1, t0);
            begin
                repeat (LAT) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        model_good(b, 1'b1);
        total++;
        if ({rx_data, rx_full, rx_ovr} !== {m_data, m_full, m_ovr}) begin
            bad++;
            $display("FAIL read_coincide got=%h/%b/%b exp=%h/%b/%b", rx_data, rx_full, rx_ovr, m_data, m_full, m_ovr);
        end
        pulse_read();
        total++;
        if ({rx_full, rx_ovr} !== 2'b00) begin
            bad++;
            $display("FAIL read_after_coincide got=%b%b exp=00", rx_full, rx_ovr);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int t0, v0, f0;
        logic [7:0] b;
        logic stp;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            v0 = v_cnt; f0 = f_cnt;
            send_frame(b, stp, -1, t0);
            if (stp) model_good(b, 1'b0);
            total++;
            if (v_cnt !== v0 + int'(stp) || f_cnt !== f0 + int'(!stp)) begin
                bad++;
                $display("FAIL rand_pulses i=%0d valid=%0d ferr=%0d stop=%b", i, v_cnt - v0, f_cnt - f0, stp);
            end
            total++;
            if ({rx_data, rx_full, rx_ovr} !== {m_data, m_full, m_ovr}) begin
                bad++;
                $display("FAIL rand_state i=%0d got=%h/%b/%b exp=%h/%b/%b", i, rx_data, rx_full, rx_ovr, m_data, m_full, m_ovr);
            end
            if ($urandom_range(0, 1) == 1) pulse_read();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] bits;
        int t0;
        test_good_frame(8'h6E);
        bits = {1'b1, 8'h77, 1'b0};
        for (int c = 0; c < 5 * N + H; c++) begin
            rx = bits[c / N];
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rx_data, rx_valid, rx_full, rx_ferr, rx_ovr, rx_busy} !== 13'h0) begin
            bad++;
            $display("FAIL midframe_reset got=%h exp=0", {rx_data, rx_valid, rx_full, rx_ferr, rx_ovr, rx_busy});
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_data = 8'h00; m_full = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        test_good_frame(8'h5A);
    endtask

    task automatic test_glitch();
        int t0;
        logic [7:0] exp_b;
`ifdef RSRX_MAJORITY_EN
        exp_b = 8'hF0;
`else
        exp_b = 8'hF4;
`endif
        pulse_read();
        send_frame(8'hF0, 1'b1, 1 + H + 3 * N, t0);
        model_good(exp_b, 1'b0);
        total++;
        if (rx_data !== m_data || last_v !== t0 + LAT) begin
            bad++;
            $display("FAIL glitch_bit2 got=%h lat=%0d exp=%h lat=%0d", rx_data, last_v - t0, m_data, LAT);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame(8'hA5);
        test_false_start();
        test_frame_err(8'h3C);
        test_back_to_back();
        test_read_coincide();
        test_random();
        test_mid_reset();
        test_glitch();
        total++;
        if (both_cnt !== 0 || wide_cnt !== 0) begin
            bad++;
            $display("FAIL pulse_shape both=%0d wide=%0d exp=0", both_cnt, wide_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
